// File: rtl/spu32_cpu_alu_mc_pkg.sv
// Shared ALU definitions: opcode encodings (including the divider ops) and
// the ALU control state encoding.
package spu32_cpu_alu_mc_pkg;

    localparam logic [3:0] ALUOP_ADD  = 4'd0;
    localparam logic [3:0] ALUOP_SUB  = 4'd1;
    localparam logic [3:0] ALUOP_AND  = 4'd2;
    localparam logic [3:0] ALUOP_OR   = 4'd3;
    localparam logic [3:0] ALUOP_XOR  = 4'd4;
    localparam logic [3:0] ALUOP_SLT  = 4'd5;
    localparam logic [3:0] ALUOP_SLTU = 4'd6;
    localparam logic [3:0] ALUOP_SLL  = 4'd7;
    localparam logic [3:0] ALUOP_SRL  = 4'd8;
    localparam logic [3:0] ALUOP_SRA  = 4'd9;
    localparam logic [3:0] ALUOP_DIV  = 4'd10;
    localparam logic [3:0] ALUOP_DIVU = 4'd11;
    localparam logic [3:0] ALUOP_REM  = 4'd12;
    localparam logic [3:0] ALUOP_REMU = 4'd13;

    typedef enum logic [1:0] {
        ALU_IDLE  = 2'd0,
        ALU_SHIFT = 2'd1,
        ALU_DIV   = 2'd2,
        ALU_FIX   = 2'd3
    } alu_state_e;

endpackage

// File: rtl/spu32_cpu_alu_mc_if.sv
// Request/response bundle between the CPU control FSM (master) and the
// multi-cycle ALU (slave).
//   I_valid/I_aluop/I_dataS1/I_dataS2 : op request
//   O_busy/O_valid/O_data             : status and result
//   O_lt/O_ltu/O_eq                   : compare flags captured at accept
interface spu32_cpu_alu_mc_if #(
    parameter int XLEN = 32
);
    logic            I_valid;
    logic [3:0]      I_aluop;
    logic [XLEN-1:0] I_dataS1;
    logic [XLEN-1:0] I_dataS2;
    logic            O_busy;
    logic            O_valid;
    logic [XLEN-1:0] O_data;
    logic            O_lt;
    logic            O_ltu;
    logic            O_eq;

    modport master (
        output I_valid, I_aluop, I_dataS1, I_dataS2,
        input  O_busy, O_valid, O_data, O_lt, O_ltu, O_eq
    );

    modport slave (
        input  I_valid, I_aluop, I_dataS1, I_dataS2,
        output O_busy, O_valid, O_data, O_lt, O_ltu, O_eq
    );
endinterface

// File: rtl/spu32_cpu_divider.sv
// Restoring unsigned iterative divider, one quotient bit per cycle.
//   start_i    : load operands (ignored if not idle is not checked; parent
//                only starts it from IDLE)
//   dividend_i / divisor_i : unsigned operands
//   done_o     : high during the cycle whose clock edge performs the final
//                iteration, so quo_o/rem_o are final from the next cycle on
//   quo_o / rem_o : quotient and remainder, held after completion
module spu32_cpu_divider #(
    parameter int XLEN = 32
) (
    input  logic            I_clk,
    input  logic            I_reset,
    input  logic            start_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] quo_o,
    output logic [XLEN-1:0] rem_o
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            run_q, run_d;
    logic [XLEN+1:0] trial;

    // Shift the next dividend bit into the partial remainder and try the
    // subtraction; the top bit of the wider result is the borrow.
    assign trial  = {1'b0, rem_q, quo_q[XLEN-1]} - {2'b00, dvs_q};
    assign done_o = run_q && (cnt_q == LAST);
    assign quo_o  = quo_q;
    assign rem_o  = rem_q;

    always_comb begin
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start_i) begin
            quo_d = dividend_i;
            rem_d = '0;
            dvs_d = divisor_i;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            if (trial[XLEN+1]) begin
                rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end else begin
                rem_d = trial[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) run_d = 1'b0;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end
endmodule

// File: rtl/spu32_cpu_alu_mc.sv
// Handshaked multi-cycle CPU ALU: single-cycle logic/arith/compare ops,
// multi-cycle shifter (SHIFT_STEP bits per cycle) and iterative divider.
//   I_clk, I_reset : clock, synchronous active-high reset
//   bus (slave)    : I_valid/I_aluop/I_dataS1/I_dataS2 request,
//                    O_busy/O_valid/O_data result, O_lt/O_ltu/O_eq flags
module spu32_cpu_alu_mc
    import spu32_cpu_alu_mc_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1,
    parameter int ENABLE_DIV = 1
) (
    input  logic                 I_clk,
    input  logic                 I_reset,
    spu32_cpu_alu_mc_if.slave    bus
);
    localparam int LOG2 = $clog2(XLEN);
    localparam bit SHIFT_1C = (SHIFT_STEP >= XLEN);
    localparam logic [LOG2-1:0] STEP = SHIFT_1C ? '0 : LOG2'(SHIFT_STEP);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] data_q, data_d, sh_q, sh_d;
    logic [LOG2-1:0] shcnt_q, shcnt_d;
    logic [3:0]      op_q, op_d;
    logic            valid_q, valid_d, lt_q, lt_d, ltu_q, ltu_d, eq_q, eq_d;
    logic            qneg_q, qneg_d, rneg_q, rneg_d;

    logic [XLEN-1:0] s1, s2, mag1, mag2, div_q, div_r, sh_next;
    logic [XLEN:0]   diff;
    logic [LOG2-1:0] shamt, step_amt;
    logic            lt_c, is_sdiv, is_rem, s1_neg, s2_neg, div_start, div_done;

    function automatic logic [XLEN-1:0] do_shift(input logic [3:0] op,
                                                 input logic [XLEN-1:0] v,
                                                 input logic [LOG2-1:0] n);
        case (op)
            ALUOP_SLL: return v << n;
            ALUOP_SRL: return v >> n;
            default:   return $signed(v) >>> n;
        endcase
    endfunction

    assign s1    = bus.I_dataS1;
    assign s2    = bus.I_dataS2;
    assign diff  = {1'b0, s1} - {1'b0, s2};
    assign lt_c  = diff[XLEN] ^ (s1[XLEN-1] ^ s2[XLEN-1]);
    assign shamt = s2[LOG2-1:0];

    assign is_sdiv = (bus.I_aluop == ALUOP_DIV) || (bus.I_aluop == ALUOP_REM);
    assign is_rem  = (bus.I_aluop == ALUOP_REM) || (bus.I_aluop == ALUOP_REMU);
    assign s1_neg  = is_sdiv && s1[XLEN-1];
    assign s2_neg  = is_sdiv && s2[XLEN-1];
    assign mag1    = s1_neg ? -s1 : s1;
    assign mag2    = s2_neg ? -s2 : s2;

    // Final step may be shorter than SHIFT_STEP.
    assign step_amt = (shcnt_q < STEP) ? shcnt_q : STEP;
    assign sh_next  = do_shift(op_q, sh_q, step_amt);

    generate
        if (ENABLE_DIV != 0) begin : g_div
            spu32_cpu_divider #(.XLEN(XLEN)) u_div (
                .I_clk      (I_clk),
                .I_reset    (I_reset),
                .start_i    (div_start),
                .dividend_i (mag1),
                .divisor_i  (mag2),
                .done_o     (div_done),
                .quo_o      (div_q),
                .rem_o      (div_r)
            );
        end else begin : g_nodiv
            assign div_done = 1'b0;
            assign div_q    = '0;
            assign div_r    = '0;
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        lt_d      = lt_q;
        ltu_d     = ltu_q;
        eq_d      = eq_q;
        op_d      = op_q;
        sh_d      = sh_q;
        shcnt_d   = shcnt_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        div_start = 1'b0;
        case (state_q)
            ALU_IDLE: begin
                if (bus.I_valid) begin
                    lt_d    = lt_c;
                    ltu_d   = diff[XLEN];
                    eq_d    = (s1 == s2);
                    op_d    = bus.I_aluop;
                    valid_d = 1'b1;
                    case (bus.I_aluop)
                        ALUOP_SUB:  data_d = diff[XLEN-1:0];
                        ALUOP_AND:  data_d = s1 & s2;
                        ALUOP_OR:   data_d = s1 | s2;
                        ALUOP_XOR:  data_d = s1 ^ s2;
                        ALUOP_SLT:  data_d = {{(XLEN-1){1'b0}}, lt_c};
                        ALUOP_SLTU: data_d = {{(XLEN-1){1'b0}}, diff[XLEN]};
                        ALUOP_SLL, ALUOP_SRL, ALUOP_SRA: begin
                            if (SHIFT_1C || shamt == '0) begin
                                data_d = do_shift(bus.I_aluop, s1, shamt);
                            end else begin
                                valid_d = 1'b0;
                                sh_d    = s1;
                                shcnt_d = shamt;
                                state_d = ALU_SHIFT;
                            end
                        end
                        ALUOP_DIV, ALUOP_DIVU, ALUOP_REM, ALUOP_REMU: begin
                            if (ENABLE_DIV == 0) begin
                                data_d = '0;
                            end else if (s2 == '0) begin
                                data_d = is_rem ? s1 : '1;
                            end else if (is_sdiv && s1 == XMIN && s2 == '1) begin
                                data_d = is_rem ? '0 : s1;
                            end else begin
                                valid_d   = 1'b0;
                                div_start = 1'b1;
                                qneg_d    = s1_neg ^ s2_neg;
                                rneg_d    = s1_neg;
                                state_d   = ALU_DIV;
                            end
                        end
                        default:    data_d = s1 + s2;
                    endcase
                end
            end
            ALU_SHIFT: begin
                sh_d    = sh_next;
                shcnt_d = shcnt_q - step_amt;
                if (shcnt_q == step_amt) begin
                    data_d  = sh_next;
                    valid_d = 1'b1;
                    state_d = ALU_IDLE;
                end
            end
            ALU_DIV: begin
                // done_o flags the last iteration edge, so results are final in FIX.
                if (div_done) state_d = ALU_FIX;
            end
            ALU_FIX: begin
                if (op_q == ALUOP_REM || op_q == ALUOP_REMU)
                    data_d = rneg_q ? -div_r : div_r;
                else
                    data_d = qneg_q ? -div_q : div_q;
                valid_d = 1'b1;
                state_d = ALU_IDLE;
            end
            default: state_d = ALU_IDLE;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state_q <= ALU_IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            lt_q    <= 1'b0;
            ltu_q   <= 1'b0;
            eq_q    <= 1'b0;
            op_q    <= ALUOP_ADD;
            sh_q    <= '0;
            shcnt_q <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            lt_q    <= lt_d;
            ltu_q   <= ltu_d;
            eq_q    <= eq_d;
            op_q    <= op_d;
            sh_q    <= sh_d;
            shcnt_q <= shcnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign bus.O_busy  = (state_q != ALU_IDLE);
    assign bus.O_valid = valid_q;
    assign bus.O_data  = data_q;
    assign bus.O_lt    = lt_q;
    assign bus.O_ltu   = ltu_q;
    assign bus.O_eq    = eq_q;
endmodule

// File: tb/tb_spu32_cpu_alu_mc.sv
// Randomized + directed bench for spu32_cpu_alu_mc. Three instances with
// SHIFT_STEP = 1, 4 and XLEN share the same request inputs; each is checked
// against an arithmetic reference model for result, latency and busy time.
module tb_spu32_cpu_alu_mc;
    import spu32_cpu_alu_mc_pkg::*;

    localparam int XLEN = 32;
    localparam logic [31:0] XMIN = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        valid;
    logic [3:0]  op;
    logic [31:0] s1, s2;
    int          tests = 0;
    int          fails = 0;

    spu32_cpu_alu_mc_if #(.XLEN(XLEN)) b1 ();
    spu32_cpu_alu_mc_if #(.XLEN(XLEN)) b4 ();
    spu32_cpu_alu_mc_if #(.XLEN(XLEN)) bx ();

    assign b1.I_valid = valid; assign b1.I_aluop = op; assign b1.I_dataS1 = s1; assign b1.I_dataS2 = s2;
    assign b4.I_valid = valid; assign b4.I_aluop = op; assign b4.I_dataS1 = s1; assign b4.I_dataS2 = s2;
    assign bx.I_valid = valid; assign bx.I_aluop = op; assign bx.I_dataS1 = s1; assign bx.I_dataS2 = s2;

    spu32_cpu_alu_mc #(.XLEN(XLEN), .SHIFT_STEP(1),    .ENABLE_DIV(1)) u_s1 (.I_clk(clk), .I_reset(rst), .bus(b1));
    spu32_cpu_alu_mc #(.XLEN(XLEN), .SHIFT_STEP(4),    .ENABLE_DIV(1)) u_s4 (.I_clk(clk), .I_reset(rst), .bus(b4));
    spu32_cpu_alu_mc #(.XLEN(XLEN), .SHIFT_STEP(XLEN), .ENABLE_DIV(1)) u_sx (.I_clk(clk), .I_reset(rst), .bus(bx));

    logic [2:0]       ov, ob;
    logic [2:0][31:0] od;
    assign ov = {bx.O_valid, b4.O_valid, b1.O_valid};
    assign ob = {bx.O_busy,  b4.O_busy,  b1.O_busy};
    assign od[0] = b1.O_data;
    assign od[1] = b4.O_data;
    assign od[2] = bx.O_data;

    int steps[3] = '{1, 4, XLEN};

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int     sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b[4:0]);
        case (o)
            ALUOP_SUB:  return a - b;
            ALUOP_AND:  return a & b;
            ALUOP_OR:   return a | b;
            ALUOP_XOR:  return a ^ b;
            ALUOP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
            ALUOP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALUOP_SLL:  return 32'(longint'(a) * (64'd1 << sh));
            ALUOP_SRL:  return 32'(longint'(a) / (64'd1 << sh));
            ALUOP_SRA:  return (sa >= 0) ? 32'(sa / (64'd1 << sh))
                                         : 32'(-((-sa + (64'd1 << sh) - 1) / (64'd1 << sh)));
            ALUOP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : (a == XMIN && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
            ALUOP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALUOP_REM:  return (b == 0) ? a : (a == XMIN && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
            ALUOP_REMU: return (b == 0) ? a : a % b;
            default:    return a + b;
        endcase
    endfunction

    function automatic int ref_n(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input int step);
        int sh;
        sh = int'(b[4:0]);
        case (o)
            ALUOP_SLL, ALUOP_SRL, ALUOP_SRA:
                return (step >= XLEN || sh == 0) ? 1 : 1 + (sh + step - 1) / step;
            ALUOP_DIV, ALUOP_REM:
                return (b == 0 || (a == XMIN && b == 32'hFFFF_FFFF)) ? 1 : XLEN + 2;
            ALUOP_DIVU, ALUOP_REMU:
                return (b == 0) ? 1 : XLEN + 2;
            default: return 1;
        endcase
    endfunction

    // Issue one op, watch 40 cycles, then check every instance. With inj set,
    // a stray ADD request is pulsed while the op is in flight; it must be dropped.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input bit inj);
        int          seen[3];
        int          pulses[3];
        int          busy_n[3];
        logic [31:0] got[3];
        for (int k = 0; k < 3; k++) begin
            seen[k] = 0; pulses[k] = 0; busy_n[k] = 0; got[k] = '0;
        end
        @(negedge clk);
        op = o; s1 = a; s2 = b; valid = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                valid = 1'b0;
                chk($sformatf("lt op%0d", o),  b1.O_lt,  ($signed(a) < $signed(b)));
                chk($sformatf("ltu op%0d", o), b1.O_ltu, (a < b));
                chk($sformatf("eq op%0d", o),  b1.O_eq,  (a == b));
            end
            if (inj && n == 3) begin valid = 1'b1; op = ALUOP_ADD; end
            if (inj && n == 4) valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (ob[k]) busy_n[k]++;
                if (ov[k]) begin
                    pulses[k]++;
                    if (seen[k] == 0) begin seen[k] = n; got[k] = od[k]; end
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("d%0d data op%0d a=%0h b=%0h", k, o, a, b), got[k], ref_res(o, a, b));
            chk($sformatf("d%0d latency op%0d", k, o), seen[k], ref_n(o, a, b, steps[k]));
            chk($sformatf("d%0d pulses op%0d", k, o), pulses[k], 1);
            chk($sformatf("d%0d busy op%0d", k, o), busy_n[k], ref_n(o, a, b, steps[k]) - 1);
        end
    endtask

    initial begin
        int          seen;
        int          pulses;
        logic [3:0]  ro;
        logic [31:0] ra, rb;
        rst = 1'b1; valid = 1'b0; op = ALUOP_ADD; s1 = '0; s2 = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("d%0d rst data", k), od[k], 0);
            chk($sformatf("d%0d rst valid", k), ov[k], 0);
            chk($sformatf("d%0d rst busy", k), ob[k], 0);
        end
        chk("rst flags", {b1.O_lt, b1.O_ltu, b1.O_eq}, 3'b000);
        rst = 1'b0;

        // Directed cases
        run_op(ALUOP_ADD,  32'hFFFF_FFFF, 32'd1, 0);
        run_op(ALUOP_SLT,  32'h8000_0000, 32'd1, 0);
        run_op(ALUOP_SRA,  32'h8000_0000, 32'd31, 0);
        run_op(ALUOP_SRL,  32'h8000_0000, 32'd31, 0);
        run_op(ALUOP_SLL,  32'h1234_5678, 32'd0, 0);
        run_op(ALUOP_SLL,  32'h0000_0001, 32'd5, 0);
        run_op(ALUOP_DIV,  32'hFFFF_FFF9, 32'd2, 1);
        run_op(ALUOP_REM,  32'hFFFF_FFF9, 32'd2, 0);
        run_op(ALUOP_DIVU, 32'd100, 32'd0, 0);
        run_op(ALUOP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(ALUOP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(ALUOP_REMU, 32'hFFFF_FFFF, 32'd7, 1);
        run_op(4'd15,      32'd40, 32'd2, 0);

        // Reset in the middle of a DIVU
        @(negedge clk);
        op = ALUOP_DIVU; s1 = 32'd1000; s2 = 32'd3; valid = 1'b1;
        pulses = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) valid = 1'b0;
            if (ov[0]) pulses++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("d%0d abort valid", k), ov[k], 0);
            chk($sformatf("d%0d abort busy", k), ob[k], 0);
            chk($sformatf("d%0d abort data", k), od[k], 0);
        end
        chk("abort no pulse", pulses, 0);
        run_op(ALUOP_ADD, 32'd2, 32'd3, 0);

        // ADD issued in the O_valid cycle of a DIVU
        @(negedge clk);
        op = ALUOP_DIVU; s1 = 32'd100; s2 = 32'd7; valid = 1'b1;
        seen = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) valid = 1'b0;
            if (seen != 0 && n == seen + 1) begin
                valid = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("d%0d b2b valid", k), ov[k], 1);
                    chk($sformatf("d%0d b2b data", k), od[k], 32'd5);
                end
            end
            if (seen == 0 && ov[0]) begin
                seen = n;
                chk("b2b divu data", od[0], 32'd14);
                op = ALUOP_ADD; s1 = 32'd2; s2 = 32'd3; valid = 1'b1;
            end
        end
        chk("b2b divu latency", seen, XLEN + 2);

        // Random stimulus
        for (int i = 0; i < 60; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = XMIN; rb = 32'hFFFF_FFFF; end
                2: rb = $urandom_range(0, 40);
                3: ra = rb;
                4: rb = $urandom_range(1, 300);
                default: ;
            endcase
            run_op(ro, ra, rb, ref_n(ro, ra, rb, 1) == XLEN + 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
